// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit.
// MULDIV_MADD_EN adds MADD/MSUB (ops 110/111) to the launchable set.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_DIV   = 3'b000,
    OP_DIVU  = 3'b001,
    OP_MULT  = 3'b010,
    OP_MULTU = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_MADD  = 3'b110,
    OP_MSUB  = 3'b111
  } md_op_t;

  typedef enum logic [1:0] {IDLE, RUN, FIX} md_state_t;

  // Ops that launch an iterative run; without the MADD build, 110/111 are no-ops.
  function automatic logic is_muldiv(md_op_t op);
    case (op)
      OP_DIV, OP_DIVU, OP_MULT, OP_MULTU: return 1'b1;
`ifdef MULDIV_MADD_EN
      OP_MADD, OP_MSUB:                   return 1'b1;
`endif
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(md_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(md_op_t op);
    return (op == OP_DIV) || (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/muldiv_iter_if.sv
// Execute-stage request/result bundle for muldiv_iter.
interface muldiv_iter_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] din1;
  logic [WIDTH-1:0] din2;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, din1, din2, flush, input busy, done, hi, lo);
  modport slave  (input start, op, din1, din2, flush, output busy, done, hi, lo);
endinterface

// File: rtl/md_iter_core.sv
// One radix-2 step: shift-add multiply or restoring divide on a 2*WIDTH accumulator.
module md_iter_core #(parameter int WIDTH = 32) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_nxt
);
  logic [WIDTH:0]   msum;
  logic [WIDTH:0]   diff;
  logic [2*WIDTH:0] sh;

  // Multiply: {partial_hi, multiplier}, LSB selects the add, carry shifts into the top.
  // Divide: {remainder, quotient}; remainder stays below the divisor, so the
  // shifted-out MSB is always zero on a failed trial.
  always_comb begin
    msum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    sh      = {acc, 1'b0};
    diff    = sh[2*WIDTH:WIDTH] - {1'b0, opnd};
    acc_nxt = {msum, acc[WIDTH-1:1]};
    if (is_div)
      acc_nxt = diff[WIDTH] ? sh[2*WIDTH-1:0] : {diff[WIDTH-1:0], sh[WIDTH-1:1], 1'b1};
  end
endmodule

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit with architectural HI/LO, flush and MTHI/MTLO.
// Define MULDIV_MADD_EN to enable MADD/MSUB accumulate into {hi,lo}.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_iter_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  md_state_t          state;
  md_op_t             op_q;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0]   opnd, hi_q, lo_q;
  logic               neg_q, rneg_q, div0_q, busy_q, done_q;

  md_op_t             op_in;
  logic               a_neg, b_neg, div_q;
  logic [WIDTH-1:0]   a_abs, b_abs, quo_s, rem_s;
  logic [2*WIDTH-1:0] prod_s, hilo_new;

  always_comb begin
    op_in = md_op_t'(bus.op);
    a_neg = is_signed_op(op_in) & bus.din1[WIDTH-1];
    b_neg = is_signed_op(op_in) & bus.din2[WIDTH-1];
    a_abs = a_neg ? -bus.din1 : bus.din1;
    b_abs = b_neg ? -bus.din2 : bus.din2;
  end

  assign div_q = is_div_op(op_q);

  md_iter_core #(.WIDTH(WIDTH)) u_core (
    .acc     (acc),
    .opnd    (opnd),
    .is_div  (div_q),
    .acc_nxt (acc_nxt)
  );

  // Sign fix-up; MIN/-1 falls out naturally as MIN with remainder 0.
  always_comb begin
    prod_s   = neg_q ? -acc : acc;
    quo_s    = div0_q ? '1 : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    rem_s    = rneg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    hilo_new = prod_s;
`ifdef MULDIV_MADD_EN
    if (op_q == OP_MADD)      hilo_new = {hi_q, lo_q} + prod_s;
    else if (op_q == OP_MSUB) hilo_new = {hi_q, lo_q} - prod_s;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= OP_DIV;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      div0_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            if (op_in == OP_MTHI) hi_q <= bus.din1;
            else if (op_in == OP_MTLO) lo_q <= bus.din1;
            else if (is_muldiv(op_in)) begin
              if (is_div_op(op_in)) begin
                acc  <= {{WIDTH{1'b0}}, a_abs};
                opnd <= b_abs;
              end else begin
                acc  <= {{WIDTH{1'b0}}, b_abs};
                opnd <= a_abs;
              end
              neg_q  <= a_neg ^ b_neg;
              rneg_q <= a_neg;
              div0_q <= is_div_op(op_in) && (bus.din2 == '0);
              op_q   <= op_in;
              cnt    <= CNT_W'(WIDTH);
              busy_q <= 1'b1;
              state  <= RUN;
            end
          end
        end
        RUN: begin
          if (bus.flush) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else if (cnt == '0) begin
            state <= FIX;
          end else begin
            acc <= acc_nxt;
            cnt <= cnt - 1'b1;
          end
        end
        FIX: begin
          busy_q <= 1'b0;
          state  <= IDLE;
          if (!bus.flush) begin
            if (div_q) begin
              lo_q <= quo_s;
              hi_q <= rem_s;
            end else begin
              {hi_q, lo_q} <= hilo_new;
            end
            done_q <= 1'b1;
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Randomized check of muldiv_iter against an arithmetic reference of HI/LO.
module tb_muldiv_iter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;
  logic [63:0] m_hl = '0;

  muldiv_iter_if #(.WIDTH(W)) bus();
  muldiv_iter #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic launches(input logic [2:0] op);
    logic l;
    l = (op < 3'd4);
`ifdef MULDIV_MADD_EN
    l = l || (op >= 3'd6);
`endif
    return l;
  endfunction

  // Architectural result of one op on {hi,lo}, straight from the ISA rules.
  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] hl);
    longint sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      3'd0: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      3'd1: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      3'd2: return 64'(sa * sb);
      3'd3: return {32'h0, a} * {32'h0, b};
      3'd4: return {a, hl[31:0]};
      3'd5: return {hl[63:32], a};
`ifdef MULDIV_MADD_EN
      3'd6: return hl + 64'(sa * sb);
      default: return hl - 64'(sa * sb);
`else
      default: return hl;
`endif
    endcase
  endfunction

  task automatic wait_done(input int base, input string tag);
    int cyc;
    cyc = base;
    while (!bus.done && cyc < W + 12) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ":lat"}, 64'(cyc), 64'(W + 2));
  endtask

  // Drives one request for a single edge; caller sits #1 after an edge.
  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1; bus.op = op; bus.din1 = a; bus.din2 = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.din1 = $urandom; bus.din2 = $urandom;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    m_hl = ref_model(op, a, b, m_hl);
    launch(op, a, b);
    chk({tag, ":busy"}, 64'(bus.busy), 64'(launches(op)));
    if (launches(op)) begin
      wait_done(0, tag);
      chk({tag, ":busy_fix"}, 64'(bus.busy), 64'h0);
    end
    chk({tag, ":hilo"}, {bus.hi, bus.lo}, m_hl);
    if (launches(op)) begin
      @(posedge clk); #1;
      chk({tag, ":pulse"}, 64'(bus.done), 64'h0);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int seen;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = '0; bus.din1 = '0; bus.din2 = '0; bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst:hilo", {bus.hi, bus.lo}, 64'h0);
    chk("rst:busy_done", {62'h0, bus.busy, bus.done}, 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(3'd2, 32'hFFFF_FFFE, 32'h3, "mult_m2x3");
    do_op(3'd3, 32'hFFFF_FFFE, 32'h3, "multu_m2x3");
    do_op(3'd0, 32'hFFFF_FFF9, 32'h2, "div_m7_2");
    do_op(3'd1, 32'h7, 32'h2, "divu_7_2");
    do_op(3'd1, 32'h1234_5678, 32'h0, "divu_by0");
    do_op(3'd0, 32'hFFFF_FFFB, 32'h0, "div_neg_by0");
    do_op(3'd0, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    do_op(3'd4, 32'hAAAA_5555, 32'h0, "mthi");
    do_op(3'd5, 32'h0000_BEEF, 32'h0, "mtlo");

    // Requests arriving while busy must be dropped, including MTHI.
    m_hl = ref_model(3'd2, 32'h0001_2345, 32'hFFFF_0007, m_hl);
    launch(3'd2, 32'h0001_2345, 32'hFFFF_0007);
    repeat (4) begin @(posedge clk); #1; end
    launch(3'd4, 32'hBAD0_BAD0, 32'h0);
    launch(3'd1, 32'h9, 32'h3);
    wait_done(6, "busy_start");
    chk("busy_start:hilo", {bus.hi, bus.lo}, m_hl);
    repeat (2) begin @(posedge clk); #1; end
    chk("busy_start:idle", {62'h0, bus.busy, bus.done}, 64'h0);

    // Flush during RUN.
    do_op(3'd4, 32'h11, 32'h0, "pre_flush_hi");
    do_op(3'd5, 32'h11, 32'h0, "pre_flush_lo");
    launch(3'd2, 32'h5, 32'h5);
    repeat (9) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_run:busy", 64'(bus.busy), 64'h0);
    seen = 0;
    repeat (W + 4) begin @(posedge clk); #1; if (bus.done) seen++; end
    chk("flush_run:done", 64'(seen), 64'h0);
    chk("flush_run:hilo", {bus.hi, bus.lo}, m_hl);

    // Flush landing on the FIX cycle.
    launch(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (W + 1) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_fix:done_busy", {62'h0, bus.busy, bus.done}, 64'h0);
    chk("flush_fix:hilo", {bus.hi, bus.lo}, m_hl);

    // Flush beats a same-cycle start in IDLE.
    bus.flush = 1'b1;
    launch(3'd4, 32'hDEAD_0001, 32'h0);
    chk("flush_mthi:hilo", {bus.hi, bus.lo}, m_hl);
    launch(3'd2, 32'h7, 32'h7);
    bus.flush = 1'b0;
    chk("flush_mult:busy", 64'(bus.busy), 64'h0);

    // MADD 3 * -4 onto {0,10}.
    do_op(3'd4, 32'h0, 32'h0, "madd_pre_hi");
    do_op(3'd5, 32'd10, 32'h0, "madd_pre_lo");
    do_op(3'd6, 32'd3, 32'hFFFF_FFFC, "madd_3xm4");
`ifdef MULDIV_MADD_EN
    chk("madd:const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFE);
`else
    chk("madd:const", {bus.hi, bus.lo}, 64'h0000_0000_0000_000A);
`endif
    do_op(3'd7, 32'h8000_0000, 32'h3, "msub");

    // Async reset mid-divide.
    do_op(3'd4, 32'h5A5A_5A5A, 32'h0, "pre_rst");
    launch(3'd0, 32'h1000, 32'h7);
    repeat (4) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    m_hl = '0;
    chk("rst_mid:hilo", {bus.hi, bus.lo}, m_hl);
    chk("rst_mid:busy", 64'(bus.busy), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 200; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      do_op(op, pick(), pick(), $sformatf("rnd%0d_op%0d", i, op));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
